sad_search_engine: RTL and testbench
====================================

SAD_SEARCH_ENGINE -- requirements
Module: sad_search_engine

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, bits per pixel (unsigned).
REQ-002 SHALL have parameter LANES, default 4, pixel pairs per beat, >=1.
REQ-003 SHALL have parameter ACC_W, default 20, SAD accumulator/result width.
REQ-004 SHALL have parameter COORD_W, default 8, coordinate and count width.
REQ-005 SHALL have the ports below; one clock; reset is synchronous and active-high.
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- num_cand  in  COORD_W  candidate positions per search.
- block_len  in  COORD_W  beats per candidate.
- search_w  in  COORD_W  candidates per row before y increments.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- frame_px  in  LANES*PIXEL_W  frame pixels, lane 0 in LSBs.
- tmpl_px  in  LANES*PIXEL_W  template pixels, lane 0 in LSBs.
- busy  out  1  high in RUN, DRAIN, DONE.
- done  out  1  one-cycle completion pulse.
- found  out  1  at least one candidate evaluated.
- min_sad  out  ACC_W  lowest SAD found.
- min_x, min_y  out  COORD_W  coordinates of min_sad.
- early_term_cnt  out  COORD_W  candidates cut short (see Configuration).

Function
REQ-006 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-007 IDLE: start=1 SHALL latch num_cand, search_w, and block_len (0 treated as 1), clear x/y/beat counters, and set min_sad to all-ones, found=0, early_term_cnt=0; go to RUN, or to DRAIN if num_cand=0.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 in_ready SHALL equal (state==RUN); a beat is accepted only on in_valid && in_ready, and stalls (in_valid=0) SHALL insert bubbles without corrupting state.
REQ-010 Per accepted beat, stage P1 SHALL register |frame_px[i]-tmpl_px[i]| per lane, stage P2 SHALL register the lane sum, and stage P3 SHALL add it to the candidate accumulator.
REQ-011 Accumulation SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-012 Accumulator SHALL clear at the first beat of each candidate; a candidate ends after block_len accepted beats.
REQ-013 On candidate end in P3, if sad < min_sad (strict), the block SHALL update min_sad, min_x and min_y on the same edge; ties SHALL keep the earlier candidate; found SHALL be set.
REQ-014 Candidate x SHALL increment per candidate and wrap to 0 after search_w-1, with y incrementing on wrap; search_w=0 SHALL behave as infinite row (y stays 0).
REQ-015 After the last beat of the last candidate is accepted, the FSM SHALL enter DRAIN for 3 cycles so P1-P3 empty.
REQ-016 done SHALL be high exactly the one DONE cycle, 3 cycles after the last beat's acceptance edge, with final min values already stable.
REQ-017 min_sad, min_x, min_y, found and early_term_cnt SHALL hold until the next accepted start.
REQ-018 The P3 commit and a new beat's P1 capture in the same cycle SHALL both take effect (no lost beats).

Reset
REQ-019 Reset SHALL take priority over all inputs, including mid-search, and return the FSM to IDLE.
REQ-020 After reset: in_ready=0, busy=0, done=0, found=0, min_sad=all-ones, min_x=min_y=0, early_term_cnt=0, pipeline valid bits cleared.

Configuration
REQ-021 Macro SAD_EARLY_TERM_EN SHALL gate early termination.
REQ-022 With SAD_EARLY_TERM_EN: once a candidate's partial SAD in P3 is >= min_sad (found=1), remaining beats of that candidate SHALL still be accepted but not accumulated, the candidate SHALL not update the min, and early_term_cnt SHALL increment once. Final min values SHALL match the non-terminating build.
REQ-023 Without SAD_EARLY_TERM_EN: every beat is accumulated and early_term_cnt SHALL be constant 0.

Verification
REQ-024 Reset, then idle 5 cycles -> in_ready=0, done=0, min_sad=0xFFFFF, min_x=min_y=0.
REQ-025 num_cand=1, block_len=2, frame lanes all 10, tmpl all 3, in_valid held high -> done 3 cycles after the 2nd beat; min_sad=56, min_x=min_y=0, found=1.
REQ-026 num_cand=4, search_w=2, block_len=1, per-candidate SADs 40, 12, 12, 30 -> min_sad=12, min_x=1, min_y=0 (tie keeps earlier candidate).
REQ-027 Same as REQ-026 with in_valid toggling 1/0 -> identical results; done delayed by the bubble count.
REQ-028 num_cand=0 with start -> done pulses after DRAIN, found=0, min_sad=0xFFFFF; Reset asserted mid-RUN -> IDLE next cycle with REQ-020 values.
REQ-029 With SAD_EARLY_TERM_EN, block_len=4, candidate SADs 8, then a candidate at 255/beat -> early_term_cnt=1, min_sad=8; without the macro, early_term_cnt=0 and the same min.

Source files
------------

// File: rtl/sad_search_engine.sv
// Block-matching SAD search: a 3-stage lane-parallel pipeline accumulates per-candidate SADs and tracks the minimum.
// Optional early termination of losing candidates is enabled by defining SAD_EARLY_TERM_EN.
module sad_search_engine #(
  parameter int PIXEL_W = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 20,
  parameter int COORD_W = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       start,
  input  logic [COORD_W-1:0]         num_cand,
  input  logic [COORD_W-1:0]         block_len,
  input  logic [COORD_W-1:0]         search_w,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*PIXEL_W-1:0]   frame_px,
  input  logic [LANES*PIXEL_W-1:0]   tmpl_px,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [ACC_W-1:0]           min_sad,
  output logic [COORD_W-1:0]         min_x,
  output logic [COORD_W-1:0]         min_y,
  output logic [COORD_W-1:0]         early_term_cnt
);

  localparam int SUM_W = PIXEL_W + $clog2(LANES + 1);
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [COORD_W-1:0]   nc_r, bl_r, sw_r;
  logic [COORD_W-1:0]   beat_cnt, cand_cnt, cur_x, cur_y;
  logic [1:0]           drain_cnt;
  logic                 done_r;

  logic [PIXEL_W-1:0]   p1_diff [LANES];
  logic                 p1_valid, p1_first, p1_last;
  logic [COORD_W-1:0]   p1_x, p1_y;

  logic [SUM_W-1:0]     p2_sum;
  logic                 p2_valid, p2_first, p2_last;
  logic [COORD_W-1:0]   p2_x, p2_y;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     min_sad_r;
  logic [COORD_W-1:0]   min_x_r, min_y_r;
  logic                 found_r;

  logic                 accept, start_acc, last_beat, last_cand;
  logic [PIXEL_W-1:0]   diff_c [LANES];
  logic [SUM_W-1:0]     lane_sum;
  logic [ACC_W-1:0]     acc_base, sat_sum;
  logic [EXT_W-1:0]     ext_sum;
  logic                 skip, commit;

  assign accept    = in_valid && (state == RUN);
  assign start_acc = start && (state == IDLE);
  assign last_beat = (beat_cnt == bl_r - COORD_W'(1));
  assign last_cand = (cand_cnt == nc_r - COORD_W'(1));

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = done_r;
  assign found    = found_r;
  assign min_sad  = min_sad_r;
  assign min_x    = min_x_r;
  assign min_y    = min_y_r;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      diff_c[i] = '0;
      if (frame_px[i*PIXEL_W +: PIXEL_W] >= tmpl_px[i*PIXEL_W +: PIXEL_W])
        diff_c[i] = frame_px[i*PIXEL_W +: PIXEL_W] - tmpl_px[i*PIXEL_W +: PIXEL_W];
      else
        diff_c[i] = tmpl_px[i*PIXEL_W +: PIXEL_W] - frame_px[i*PIXEL_W +: PIXEL_W];
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++)
      lane_sum = lane_sum + SUM_W'(p1_diff[i]);
  end

  // Saturating accumulate; the first beat of a candidate restarts from zero.
  always_comb begin
    acc_base = p2_first ? '0 : acc;
    ext_sum  = EXT_W'(acc_base) + EXT_W'(p2_sum);
    sat_sum  = (ext_sum > EXT_W'(ACC_MAX)) ? ACC_MAX : ext_sum[ACC_W-1:0];
  end

`ifdef SAD_EARLY_TERM_EN
  logic                 term_r, term_prior, new_term;
  logic [COORD_W-1:0]   et_cnt_r;

  // A candidate already known to lose skips its remaining beats and never commits.
  always_comb begin
    term_prior = !p2_first && term_r;
    new_term   = !term_prior && found_r && !p2_last && (sat_sum >= min_sad_r);
    skip       = term_prior;
    commit     = p2_last && !term_prior && (sat_sum < min_sad_r);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      term_r   <= 1'b0;
      et_cnt_r <= '0;
    end else if (start_acc) begin
      term_r   <= 1'b0;
      et_cnt_r <= '0;
    end else if (p2_valid) begin
      term_r <= term_prior || new_term;
      if (new_term)
        et_cnt_r <= et_cnt_r + COORD_W'(1);
    end
  end

  assign early_term_cnt = et_cnt_r;
`else
  always_comb begin
    skip   = 1'b0;
    commit = p2_last && (sat_sum < min_sad_r);
  end

  assign early_term_cnt = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      nc_r      <= '0;
      bl_r      <= '0;
      sw_r      <= '0;
      beat_cnt  <= '0;
      cand_cnt  <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      drain_cnt <= '0;
      done_r    <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++)
        p1_diff[i] <= '0;
      p1_valid  <= 1'b0;
      p1_first  <= 1'b0;
      p1_last   <= 1'b0;
      p1_x      <= '0;
      p1_y      <= '0;
      p2_sum    <= '0;
      p2_valid  <= 1'b0;
      p2_first  <= 1'b0;
      p2_last   <= 1'b0;
      p2_x      <= '0;
      p2_y      <= '0;
      acc       <= '0;
      min_sad_r <= '1;
      min_x_r   <= '0;
      min_y_r   <= '0;
      found_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;

      p1_valid <= accept;
      if (accept) begin
        p1_diff  <= diff_c;
        p1_first <= (beat_cnt == '0);
        p1_last  <= last_beat;
        p1_x     <= cur_x;
        p1_y     <= cur_y;
      end

      p2_valid <= p1_valid;
      if (p1_valid) begin
        p2_sum   <= lane_sum;
        p2_first <= p1_first;
        p2_last  <= p1_last;
        p2_x     <= p1_x;
        p2_y     <= p1_y;
      end

      if (p2_valid) begin
        if (!skip)
          acc <= sat_sum;
        if (commit) begin
          min_sad_r <= sat_sum;
          min_x_r   <= p2_x;
          min_y_r   <= p2_y;
        end
        if (p2_last)
          found_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            nc_r      <= num_cand;
            bl_r      <= (block_len == '0) ? COORD_W'(1) : block_len;
            sw_r      <= search_w;
            beat_cnt  <= '0;
            cand_cnt  <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            drain_cnt <= '0;
            min_sad_r <= '1;
            min_x_r   <= '0;
            min_y_r   <= '0;
            found_r   <= 1'b0;
            state     <= (num_cand == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              cand_cnt <= cand_cnt + COORD_W'(1);
              if (sw_r != '0 && cur_x == sw_r - COORD_W'(1)) begin
                cur_x <= '0;
                cur_y <= cur_y + COORD_W'(1);
              end else begin
                cur_x <= cur_x + COORD_W'(1);
              end
              if (last_cand) begin
                drain_cnt <= '0;
                state     <= DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt + COORD_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_search_engine.sv
// Scoreboard bench for sad_search_engine: searches push expected results, a done-triggered monitor checks them.
module tb_sad_search_engine;
  localparam int PW = 8;
  localparam int LN = 4;
  localparam int AW = 20;
  localparam int CW = 8;
  localparam int DW = PW * LN;
`ifdef SAD_EARLY_TERM_EN
  localparam logic [CW-1:0] ET_EXP = 8'd1;
`else
  localparam logic [CW-1:0] ET_EXP = 8'd0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_cand = '0;
  logic [CW-1:0] block_len = '0;
  logic [CW-1:0] search_w = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] frame_px = '0;
  logic [DW-1:0] tmpl_px = '0;
  logic          busy, done, found;
  logic [AW-1:0] min_sad;
  logic [CW-1:0] min_x, min_y, early_term_cnt;

  sad_search_engine #(.PIXEL_W(PW), .LANES(LN), .ACC_W(AW), .COORD_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .num_cand(num_cand),
    .block_len(block_len), .search_w(search_w), .in_valid(in_valid),
    .in_ready(in_ready), .frame_px(frame_px), .tmpl_px(tmpl_px),
    .busy(busy), .done(done), .found(found), .min_sad(min_sad),
    .min_x(min_x), .min_y(min_y), .early_term_cnt(early_term_cnt)
  );

  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [AW-1:0] sad;
    logic [CW-1:0] x, y;
    logic          fnd;
    logic [CW-1:0] et;
    int            edge_n;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] fq[$], tq[$];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("done_edge", edge_cnt, mon_e.edge_n);
        check("min_sad", min_sad, mon_e.sad);
        check("min_x", min_x, mon_e.x);
        check("min_y", min_y, mon_e.y);
        check("found", found, mon_e.fnd);
        check("early_term_cnt", early_term_cnt, mon_e.et);
      end
    end
  end

  task automatic beat(input logic [DW-1:0] f, input logic [DW-1:0] t);
    fq.push_back(f);
    tq.push_back(t);
  endtask

  // hold_start keeps start high with different parameters while the search runs.
  task automatic run_search(input logic [CW-1:0] nc, input logic [CW-1:0] bl,
                            input logic [CW-1:0] sw, input int bub, input bit hold_start,
                            input logic [AW-1:0] e_sad, input logic [CW-1:0] ex,
                            input logic [CW-1:0] ey, input logic efnd, input logic [CW-1:0] eet);
    exp_t e;
    int   guard;
    e.sad = e_sad; e.x = ex; e.y = ey; e.fnd = efnd; e.et = eet; e.edge_n = 0;
    @(negedge Clk);
    start = 1'b1; num_cand = nc; block_len = bl; search_w = sw;
    if (nc == '0) begin
      e.edge_n = edge_cnt + 4;
      exp_q.push_back(e);
    end
    @(negedge Clk);
    if (hold_start) begin
      num_cand = 8'd9; block_len = 8'd3; search_w = 8'd1;
    end else begin
      start = 1'b0;
    end
    while (fq.size() > 0) begin
      repeat (bub) begin
        in_valid = 1'b0;
        @(negedge Clk);
      end
      in_valid = 1'b1;
      frame_px = fq.pop_front();
      tmpl_px  = tq.pop_front();
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge Clk);
        guard++;
      end
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      if (fq.size() == 0) begin
        e.edge_n = edge_cnt + 4;
        exp_q.push_back(e);
      end
      @(negedge Clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      @(negedge Clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
      exp_q.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_min_sad"}, min_sad, 32'hFFFFF);
    check({tag, "_min_x"}, min_x, 0);
    check({tag, "_min_y"}, min_y, 0);
    check({tag, "_et"}, early_term_cnt, 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    check_idle_reset("rst");

    // 4 lanes x |10-3| x 2 beats = 56
    beat({4{8'd10}}, {4{8'd3}});
    beat({4{8'd10}}, {4{8'd3}});
    run_search(8'd1, 8'd2, 8'd0, 0, 1'b0, 20'd56, 8'd0, 8'd0, 1'b1, 8'd0);

    // SADs 40, 12, 12, 30 over a 2-wide row; tie keeps (1,0)
    for (int r = 0; r < 2; r++) begin
      beat({4{8'd10}}, {4{8'd0}});
      beat({4{8'd0}}, {4{8'd3}});
      beat({8'd0, 8'd9, 8'd0, 8'd5}, {8'd3, 8'd9, 8'd4, 8'd0});
      beat({8'd0, 8'd10, 8'd10, 8'd10}, {4{8'd0}});
      if (r == 0)
        run_search(8'd4, 8'd1, 8'd2, 0, 1'b0, 20'd12, 8'd1, 8'd0, 1'b1, 8'd0);
      else
        run_search(8'd4, 8'd1, 8'd2, 1, 1'b1, 20'd12, 8'd1, 8'd0, 1'b1, 8'd0);
    end

    // SADs 50, 40, 20: minimum lands on the second row
    beat({8'd10, 8'd10, 8'd10, 8'd20}, {4{8'd0}});
    beat({4{8'd10}}, {4{8'd0}});
    beat({4{8'd5}}, {4{8'd0}});
    run_search(8'd3, 8'd1, 8'd2, 0, 1'b0, 20'd20, 8'd0, 8'd1, 1'b1, 8'd0);

    // block_len 0 acts as 1; search_w 0 keeps y at 0
    beat({4{8'd5}}, {4{8'd0}});
    beat({4{8'd2}}, {4{8'd0}});
    run_search(8'd2, 8'd0, 8'd0, 0, 1'b0, 20'd8, 8'd1, 8'd0, 1'b1, 8'd0);

    run_search(8'd0, 8'd4, 8'd0, 0, 1'b0, 20'hFFFFF, 8'd0, 8'd0, 1'b0, 8'd0);

    // candidate SAD 8, then 1020 per beat
    repeat (4) beat({8'd0, 8'd0, 8'd1, 8'd1}, {4{8'd0}});
    repeat (4) beat({4{8'hFF}}, {4{8'd0}});
    run_search(8'd2, 8'd4, 8'd0, 0, 1'b0, 20'd8, 8'd0, 8'd0, 1'b1, ET_EXP);

    // reset in the middle of a search after a minimum was committed
    @(negedge Clk);
    start = 1'b1; num_cand = 8'd3; block_len = 8'd1; search_w = 8'd2;
    @(negedge Clk);
    start = 1'b0;
    in_valid = 1'b1; frame_px = {4{8'd10}}; tmpl_px = {4{8'd0}};
    @(negedge Clk);
    frame_px = {4{8'd0}}; tmpl_px = {4{8'd3}};
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("mid_min_sad", min_sad, 32'd12);
    check("mid_min_x", min_x, 1);
    check("mid_in_ready", in_ready, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check_idle_reset("midrst");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    beat({4{8'd10}}, {4{8'd3}});
    beat({4{8'd10}}, {4{8'd3}});
    run_search(8'd1, 8'd2, 8'd0, 0, 1'b0, 20'd56, 8'd0, 8'd0, 1'b1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
